bf_pipe_unit: RTL and testbench

Pipelined, multi-lane modular butterfly for the NTT/INTT datapath. It replaces the single-cycle, single-mode butterfly.
- Supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) per transaction.
- Parametrised in coefficient width, modulus and lane count.
- Valid/ready handshake with full backpressure.
- Carries a sideband tag so the NTT controller can route write-back addresses.

---
 rtl/ntt_pkg.sv | 12 +
 rtl/bf_pipe_unit_mod_red.sv | 53 +++++
 rtl/bf_pipe_unit.sv | 175 +++++++++++++++++
 tb/tb_bf_pipe_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and butterfly mode encodings.
package ntt_pkg;

    localparam int unsigned BIT_LEN = 23;
    localparam int unsigned Q       = 8380417;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } bf_mode_e;

endpackage

// File: rtl/bf_pipe_unit_mod_red.sv
// Registered Barrett reduction of a 2*BIT_LEN-bit value modulo q, with enable.
module mod_red #(
    parameter int unsigned BIT_LEN = ntt_pkg::BIT_LEN,
    parameter int unsigned q       = ntt_pkg::Q
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [2*BIT_LEN-1:0] x,
    output logic [BIT_LEN-1:0]   r
);

    localparam int unsigned W  = BIT_LEN;
    localparam int unsigned PW = 2 * W;
    // Bit length of q; q is an odd prime so $clog2 gives it directly.
    localparam int unsigned K  = $clog2(q);
    localparam int unsigned HW = PW - K + 1;
    localparam int unsigned MW = K + 1;
    localparam int unsigned RW = W + 2;
    localparam logic [MW-1:0] MU   = MW'((64'd1 << (2 * K)) / 64'(q));
    localparam logic [RW-1:0] Q_R  = RW'(q);
    localparam logic [RW-1:0] Q2_R = RW'(2 * q);

    logic [HW-1:0]    x_hi;
    logic [HW+MW-1:0] prod;
    logic [HW-1:0]    qhat;
    logic [RW-1:0]    rem;
    logic [W-1:0]     red_c;

    // Quotient estimate is at most 2 low, so the remainder lies in [0, 3q).
    always_comb begin
        x_hi  = x[PW-1:K-1];
        prod  = (HW+MW)'(x_hi) * (HW+MW)'(MU);
        qhat  = HW'(prod >> (K + 1));
        rem   = RW'(x) - RW'(qhat) * Q_R;
        red_c = W'(rem);
        if (rem >= Q2_R) begin
            red_c = W'(rem - Q2_R);
        end else if (rem >= Q_R) begin
            red_c = W'(rem - Q_R);
        end
    end

    // Result register; holds when en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
        end else if (en) begin
            r <= red_c;
        end
    end

endmodule

// File: rtl/bf_pipe_unit.sv
// Three-stage, multi-lane CT/GS modular butterfly with valid/ready backpressure.
module bf_pipe_unit #(
    parameter int unsigned BIT_LEN = ntt_pkg::BIT_LEN,
    parameter int unsigned q       = ntt_pkg::Q,
    parameter int unsigned LANES   = 1,
    parameter int unsigned TAG_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mode,
    input  logic [LANES*BIT_LEN-1:0] in0,
    input  logic [LANES*BIT_LEN-1:0] in1,
    input  logic [BIT_LEN-1:0]       phi,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*BIT_LEN-1:0] out0,
    output logic [LANES*BIT_LEN-1:0] out1,
    output logic [TAG_W-1:0]         out_tag
);

    import ntt_pkg::*;

    localparam int unsigned W  = BIT_LEN;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned DW = LANES * W;
    localparam logic [W:0]  Q_E = (W+1)'(q);

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_E) begin
            s = s - Q_E;
        end
        return W'(s);
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) begin
            d = d + Q_E;
        end
        return W'(d);
    endfunction

    logic             stall;
    logic             en;
    logic             out_en;
    bf_mode_e         in_mode;

    logic             s1_valid;
    logic             s2_valid;
    bf_mode_e         s1_mode;
    bf_mode_e         s2_mode;
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] s2_tag;
    logic [W-1:0]     s1_w;

    // Stage 1: CT keeps a and w*b; GS keeps (a+b) and (a-b).
    logic [W-1:0]     s1_a_nxt [LANES];
    logic [PW-1:0]    s1_p_nxt [LANES];
    logic [W-1:0]     s1_a     [LANES];
    logic [PW-1:0]    s1_p     [LANES];
    // Stage 2: CT keeps a and t; GS keeps (a+b) and (a-b)*w.
    logic [W-1:0]     s2_a     [LANES];
    logic [PW-1:0]    s2_p     [LANES];
    logic [W-1:0]     s2_t     [LANES];
    // Stage 3 reducer input: GS product, or CT difference (already < q).
    logic [PW-1:0]    s3_x     [LANES];
    logic [DW-1:0]    out0_nxt;

    // Whole pipeline freezes while the output slot is held by downstream.
    always_comb begin
        stall    = out_valid && !out_ready;
        en       = !stall;
        in_ready = en;
        out_en   = en && s2_valid;
    end

    // Stage 1 operand preparation per lane.
    always_comb begin
        in_mode = bf_mode_e'(mode);
        for (int k = 0; k < LANES; k++) begin
            s1_a_nxt[k] = in0[k*W +: W];
            s1_p_nxt[k] = PW'(phi) * PW'(in1[k*W +: W]);
            if (in_mode == MODE_GS) begin
                s1_a_nxt[k] = add_mod(in0[k*W +: W], in1[k*W +: W]);
                s1_p_nxt[k] = PW'(sub_mod(in0[k*W +: W], in1[k*W +: W]));
            end
        end
    end

    // Stage 3 operand selection and CT add.
    always_comb begin
        out0_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            s3_x[k]              = s2_p[k];
            out0_nxt[k*W +: W]   = s2_a[k];
            if (s2_mode == MODE_CT) begin
                s3_x[k]            = PW'(sub_mod(s2_a[k], s2_t[k]));
                out0_nxt[k*W +: W] = add_mod(s2_a[k], s2_t[k]);
            end
        end
    end

    // Slot valid bits; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    // Stage 1 and 2 payload registers; bubbles carry don't-care data.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_mode <= in_mode;
            s1_tag  <= in_tag;
            s1_w    <= phi;
            s2_mode <= s1_mode;
            s2_tag  <= s1_tag;
            for (int k = 0; k < LANES; k++) begin
                s1_a[k] <= s1_a_nxt[k];
                s1_p[k] <= s1_p_nxt[k];
                s2_a[k] <= s1_a[k];
                s2_p[k] <= PW'(s1_p[k][W-1:0]) * PW'(s1_w);
            end
        end
    end

    // Output payload only loads real results, so bubbles never disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_tag <= '0;
            out0    <= '0;
        end else if (out_en) begin
            out_tag <= s2_tag;
            out0    <= out0_nxt;
        end
    end

    // Per-lane reducers: CT twiddle product into stage 2, final out1 into stage 3.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mod_red #(
            .BIT_LEN (W),
            .q       (q)
        ) u_red_t (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .x     (s1_p[k]),
            .r     (s2_t[k])
        );

        mod_red #(
            .BIT_LEN (W),
            .q       (q)
        ) u_red_o (
            .clk   (clk),
            .reset (reset),
            .en    (out_en),
            .x     (s3_x[k]),
            .r     (out1[k*W +: W])
        );
    end

endmodule

// File: tb/tb_bf_pipe_unit.sv
// Directed and streaming checks for the pipelined CT/GS butterfly.
module tb_bf_pipe_unit;

    localparam int unsigned W     = 23;
    localparam int unsigned LANES = 4;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned DW    = LANES * W;
    localparam longint unsigned QM = 64'd8380417;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [DW-1:0]    in0;
    logic [DW-1:0]    in1;
    logic [W-1:0]     phi;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out0;
    logic [DW-1:0]    out1;
    logic [TAG_W-1:0] out_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bf_pipe_unit #(
        .BIT_LEN (W),
        .q       (8380417),
        .LANES   (LANES),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in0       (in0),
        .in1       (in1),
        .phi       (phi),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out_tag   (out_tag)
    );

    typedef struct {
        bit          md;
        int unsigned a;
        int unsigned b;
        int unsigned w;
        logic [7:0]  tag;
        int unsigned e0;
        int unsigned e1;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] o0;
        logic [DW-1:0] o1;
        logic [7:0]    tag;
    } exp_t;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input int unsigned v);
        logic [W-1:0] x;
        x = W'(v);
        return {LANES{x}};
    endfunction

    // Golden butterfly using plain 64-bit modular arithmetic.
    task automatic model(input bit md, input longint unsigned a, input longint unsigned b,
                         input longint unsigned w, output logic [W-1:0] o0, output logic [W-1:0] o1);
        longint unsigned t;
        if (!md) begin
            t  = (w * b) % QM;
            o0 = W'((a + t) % QM);
            o1 = W'((a + QM - t) % QM);
        end else begin
            t  = (a + QM - b) % QM;
            o0 = W'((a + b) % QM);
            o1 = W'((t * w) % QM);
        end
    endtask

    // Streams n random transactions; mode_pat 0 alternates CT/GS, 1 random.
    // ready_pat 0 = always ready, 1 = 4-cycle stall window, 2 = random.
    task automatic run_stream(input string nm, input int n, input int mode_pat, input int ready_pat);
        exp_t          sb[$];
        exp_t          ex;
        int            sent;
        int            cyc;
        int            gaps;
        bit            have;
        bit            started;
        bit            prev_stall;
        bit            cm;
        logic [DW-1:0] ca, cb, e0, e1, h0, h1;
        logic [W-1:0]  cw, la, lb, o0, o1;
        logic [7:0]    ht;
        sent = 0; cyc = 0; gaps = 0; have = 0; started = 0; prev_stall = 0;
        cm = 0; ca = '0; cb = '0; e0 = '0; e1 = '0; h0 = '0; h1 = '0; cw = '0; ht = '0;
        while ((sent < n || sb.size() != 0) && cyc < n * 8 + 100) begin
            @(negedge clk);
            cyc++;
            case (ready_pat)
                0:       out_ready = 1'b1;
                1:       out_ready = !(cyc >= 6 && cyc < 10);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (sent < n) begin
                if (!have) begin
                    cm = (mode_pat == 0) ? sent[0] : bit'($urandom_range(0, 1));
                    cw = W'($urandom_range(0, 8380416));
                    for (int k = 0; k < LANES; k++) begin
                        la = W'($urandom_range(0, 8380416));
                        lb = W'($urandom_range(0, 8380416));
                        ca[k*W +: W] = la;
                        cb[k*W +: W] = lb;
                        model(cm, longint'(la), longint'(lb), longint'(cw), o0, o1);
                        e0[k*W +: W] = o0;
                        e1[k*W +: W] = o1;
                    end
                    have = 1;
                end
                mode = cm; in0 = ca; in1 = cb; phi = cw; in_tag = 8'(sent); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check({nm, "_hold_out0"}, 128'(out0), 128'(h0));
                check({nm, "_hold_out1"}, 128'(out1), 128'(h1));
                check({nm, "_hold_tag"}, 128'(out_tag), 128'(ht));
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                check({nm, "_stall_in_ready"}, 128'(in_ready), 128'(0));
                h0 = out0; h1 = out1; ht = out_tag;
            end
            if (out_valid) started = 1;
            if (ready_pat == 0 && started && !out_valid && sb.size() != 0) gaps++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check({nm, "_extra_output"}, 128'(1), 128'(0));
                end else begin
                    ex = sb.pop_front();
                    check({nm, "_out0"}, 128'(out0), 128'(ex.o0));
                    check({nm, "_out1"}, 128'(out1), 128'(ex.o1));
                    check({nm, "_tag"}, 128'(out_tag), 128'(ex.tag));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{o0: e0, o1: e1, tag: 8'(sent)});
                sent++;
                have = 0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({nm, "_sent"}, 128'(sent), 128'(n));
        check({nm, "_drained"}, 128'(sb.size()), 128'(0));
        if (ready_pat == 0) check({nm, "_gaps"}, 128'(gaps), 128'(0));
    endtask

    // Pulses reset for one edge and checks the pipeline comes back empty.
    task automatic reset_and_check(input string nm);
        int emitted;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({nm, "_out_valid"}, 128'(out_valid), 128'(0));
        check({nm, "_out0"}, 128'(out0), 128'(0));
        check({nm, "_out1"}, 128'(out1), 128'(0));
        check({nm, "_out_tag"}, 128'(out_tag), 128'(0));
        check({nm, "_in_ready"}, 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        emitted = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) emitted++;
        end
        check({nm, "_no_emission"}, 128'(emitted), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        vt[0] = '{md: 0, a: 1,       b: 2,       w: 3,       tag: 8'h01, e0: 7,       e1: 8380412};
        vt[1] = '{md: 1, a: 5,       b: 7,       w: 2,       tag: 8'h5A, e0: 12,      e1: 8380413};
        vt[2] = '{md: 0, a: 8380416, b: 8380416, w: 8380416, tag: 8'h03, e0: 0,       e1: 8380415};
        vt[3] = '{md: 0, a: 0,       b: 0,       w: 12345,   tag: 8'h04, e0: 0,       e1: 0};
        vt[4] = '{md: 1, a: 8380416, b: 8380416, w: 5,       tag: 8'h05, e0: 8380415, e1: 0};
        vt[5] = '{md: 1, a: 0,       b: 1,       w: 1,       tag: 8'h06, e0: 1,       e1: 8380416};
        vt[6] = '{md: 0, a: 100,     b: 1,       w: 8380416, tag: 8'h07, e0: 99,      e1: 101};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
        in0 = '0; in1 = '0; phi = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out0", 128'(out0), 128'(0));
        check("rst_out1", 128'(out1), 128'(0));
        check("rst_out_tag", 128'(out_tag), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            mode      = vt[i].md;
            in0       = rep(vt[i].a);
            in1       = rep(vt[i].b);
            phi       = W'(vt[i].w);
            in_tag    = vt[i].tag;
            in_valid  = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(1));
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                check($sformatf("vec%0d_lat%0d", i, c), 128'(out_valid), 128'(c == 3));
            end
            check($sformatf("vec%0d_out0", i), 128'(out0), 128'(rep(vt[i].e0)));
            check($sformatf("vec%0d_out1", i), 128'(out1), 128'(rep(vt[i].e1)));
            check($sformatf("vec%0d_tag", i), 128'(out_tag), 128'(vt[i].tag));
        end

        run_stream("bp", 6, 0, 1);
        run_stream("thru", 40, 1, 0);
        run_stream("rand", 1000, 1, 2);

        // Two transactions in flight, then reset.
        @(negedge clk);
        out_ready = 1'b1; mode = 1'b0; in0 = rep(9); in1 = rep(4); phi = W'(3); in_tag = 8'hA1;
        in_valid = 1'b1;
        @(negedge clk);
        mode = 1'b1; in_tag = 8'hA2;
        reset_and_check("rst_flight");

        // Stall the output with the pipeline full, then reset.
        @(negedge clk);
        out_ready = 1'b0; mode = 1'b0; in0 = rep(11); in1 = rep(22); phi = W'(33); in_tag = 8'hB0;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst_stall_pre_valid", 128'(out_valid), 128'(1));
        check("rst_stall_pre_in_ready", 128'(in_ready), 128'(0));
        out_ready = 1'b0;
        reset_and_check("rst_stall");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
